// File: rtl/regfile_mp.sv
// Multi-port register file: two async read ports, two write ports (ALU/load),
// a per-register busy scoreboard and a handshaked register dump stream.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int FORWARD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              busy_set_en,
  input  logic [ADDR_W-1:0] busy_set_addr,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic {IDLE, SEND} dumpState_e;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr0Commit, wr1Commit;

  dumpState_e        state_q, state_d;
  logic [ADDR_W-1:0] dumpAddr_q, dumpAddr_d, dumpAddrNext;
  logic [DATA_W-1:0] dumpData_q, dumpData_d;

  assign wr0Commit = wr0_en && !((ZERO_REG != 0) && (wr0_addr == ZERO_ADDR));
  assign wr1Commit = wr1_en && !((ZERO_REG != 0) && (wr1_addr == ZERO_ADDR));

  // wr1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wr0Commit) regs_q[wr0_addr] <= wr0_data;
      if (wr1Commit) regs_q[wr1_addr] <= wr1_data;
    end
  end

  // A pending-load set outranks a same-cycle writeback clear.
  always_comb begin
    busy_d = busy_q;
    if (wr0Commit) busy_d[wr0_addr] = 1'b0;
    if (wr1Commit) busy_d[wr1_addr] = 1'b0;
    if (busy_set_en) busy_d[busy_set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_addr_a];
  assign busy_b = busy_q[rd_addr_b];

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if ((ZERO_REG != 0) && (rd_addr_a == ZERO_ADDR))
      rd_data_a = '0;
    else if ((FORWARD != 0) && wr1_en && (rd_addr_a == wr1_addr))
      rd_data_a = wr1_data;
    else if ((FORWARD != 0) && wr0_en && (rd_addr_a == wr0_addr))
      rd_data_a = wr0_data;
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if ((ZERO_REG != 0) && (rd_addr_b == ZERO_ADDR))
      rd_data_b = '0;
    else if ((FORWARD != 0) && wr1_en && (rd_addr_b == wr1_addr))
      rd_data_b = wr1_data;
    else if ((FORWARD != 0) && wr0_en && (rd_addr_b == wr0_addr))
      rd_data_b = wr0_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dumpAddr_q <= '0;
      dumpData_q <= '0;
    end else begin
      state_q    <= state_d;
      dumpAddr_q <= dumpAddr_d;
      dumpData_q <= dumpData_d;
    end
  end

  assign dumpAddrNext = dumpAddr_q + ONE_ADDR;

  // Captures use the stored array, so same-edge writes never leak into a beat.
  always_comb begin
    state_d    = state_q;
    dumpAddr_d = dumpAddr_q;
    dumpData_d = dumpData_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d    = SEND;
          dumpAddr_d = '0;
          dumpData_d = regs_q[0];
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (dumpAddr_q == LAST_ADDR) begin
            state_d = IDLE;
          end else begin
            dumpAddr_d = dumpAddrNext;
            dumpData_d = regs_q[dumpAddrNext];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = (state_q == SEND);
    dump_addr  = dumpAddr_q;
    dump_data  = dumpData_q;
    dump_last  = (state_q == SEND) && (dumpAddr_q == LAST_ADDR);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance and a non-forwarding
// instance share one stimulus stream.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  rdAddrA, rdAddrB, wr0Addr, wr1Addr, busySetAddr;
  logic [31:0] wr0Data, wr1Data;
  logic        wr0En, wr1En, busySetEn, dumpStart, dumpReady;

  logic [31:0] rdDataA, rdDataB, dumpData;
  logic        busyA, busyB, dumpValid, dumpLast;
  logic [4:0]  dumpAddr;

  logic [31:0] rdDataANf, rdDataBNf, dumpDataNf;
  logic        busyANf, busyBNf, dumpValidNf, dumpLastNf;
  logic [4:0]  dumpAddrNf;

  int assertCount = 0;
  int failCount   = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .FORWARD(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rdAddrA), .rd_data_a(rdDataA),
    .rd_addr_b(rdAddrB), .rd_data_b(rdDataB),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .busy_set_en(busySetEn), .busy_set_addr(busySetAddr),
    .busy_a(busyA), .busy_b(busyB),
    .dump_start(dumpStart), .dump_valid(dumpValid), .dump_ready(dumpReady),
    .dump_addr(dumpAddr), .dump_data(dumpData), .dump_last(dumpLast)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .FORWARD(0)) dutNf (
    .clk(clk), .rst(rst),
    .rd_addr_a(rdAddrA), .rd_data_a(rdDataANf),
    .rd_addr_b(rdAddrB), .rd_data_b(rdDataBNf),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .busy_set_en(busySetEn), .busy_set_addr(busySetAddr),
    .busy_a(busyANf), .busy_b(busyBNf),
    .dump_start(dumpStart), .dump_valid(dumpValidNf), .dump_ready(dumpReady),
    .dump_addr(dumpAddrNf), .dump_data(dumpDataNf), .dump_last(dumpLastNf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    wr0En = 1'b0; wr1En = 1'b0; busySetEn = 1'b0; dumpStart = 1'b0;
    wr0Addr = '0; wr1Addr = '0; busySetAddr = '0;
    wr0Data = '0; wr1Data = '0;
  endtask

  function automatic logic [31:0] dumpExpect(input int idx);
    if (idx == 3) return 32'hFF;
    if (idx == 4) return 32'hAB;
    return 32'(idx * 16);
  endfunction

  initial begin
    rst = 1'b1; dumpReady = 1'b0; rdAddrA = '0; rdAddrB = '0;
    clearInputs();
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", {31'b0, dumpValid}, 32'd0);
    checkOutput("rst_addr", {27'b0, dumpAddr}, 32'd0);
    checkOutput("rst_data", dumpData, 32'd0);
    checkOutput("rst_last", {31'b0, dumpLast}, 32'd0);
    rdAddrA = 5'd5; rdAddrB = 5'd31;
    #1;
    checkOutput("rst_rd_a", rdDataA, 32'd0);
    checkOutput("rst_busy_a", {31'b0, busyA}, 32'd0);
    rst = 1'b0;

    // basic write/read, with in-cycle forwarding comparison
    wr0En = 1'b1; wr0Addr = 5'd5; wr0Data = 32'hDEADBEEF;
    #1;
    checkOutput("fwd_wr0_a", rdDataA, 32'hDEADBEEF);
    checkOutput("nofwd_wr0_a", rdDataANf, 32'd0);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("wr_r5_a", rdDataA, 32'hDEADBEEF);
    checkOutput("nofwd_r5_a", rdDataANf, 32'hDEADBEEF);

    rdAddrA = 5'd0; wr0En = 1'b1; wr0Addr = 5'd0; wr0Data = 32'h1234;
    #1;
    checkOutput("r0_fwd_a", rdDataA, 32'd0);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("r0_a", rdDataA, 32'd0);
    checkOutput("nofwd_r0_a", rdDataANf, 32'd0);

    // write collision on r7
    wr0En = 1'b1; wr0Addr = 5'd7; wr0Data = 32'h5;
    applyStimulus();
    rdAddrB = 5'd7;
    wr0En = 1'b1; wr0Addr = 5'd7; wr0Data = 32'h11;
    wr1En = 1'b1; wr1Addr = 5'd7; wr1Data = 32'h22;
    #1;
    checkOutput("coll_fwd_b", rdDataB, 32'h22);
    checkOutput("coll_nofwd_b", rdDataBNf, 32'h5);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("coll_r7_b", rdDataB, 32'h22);
    checkOutput("coll_nofwd_r7_b", rdDataBNf, 32'h22);

    // scoreboard
    rdAddrA = 5'd9; busySetEn = 1'b1; busySetAddr = 5'd9;
    #1;
    checkOutput("busy_pre", {31'b0, busyA}, 32'd0);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("busy_set", {31'b0, busyA}, 32'd1);
    wr1En = 1'b1; wr1Addr = 5'd9; wr1Data = 32'h99;
    #1;
    checkOutput("busy_no_fwd_clear", {31'b0, busyA}, 32'd1);
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("busy_cleared", {31'b0, busyA}, 32'd0);
    checkOutput("r9_load", rdDataA, 32'h99);
    busySetEn = 1'b1; busySetAddr = 5'd9;
    wr0En = 1'b1; wr0Addr = 5'd9; wr0Data = 32'h98;
    applyStimulus();
    clearInputs();
    rdAddrB = 5'd9;
    #1;
    checkOutput("busy_set_wins", {31'b0, busyA}, 32'd1);
    checkOutput("busy_set_wins_b", {31'b0, busyB}, 32'd1);
    checkOutput("r9_wr0", rdDataA, 32'h98);
    rdAddrA = 5'd0; busySetEn = 1'b1; busySetAddr = 5'd0;
    applyStimulus();
    clearInputs();
    #1;
    checkOutput("busy_r0", {31'b0, busyA}, 32'd0);

    // load rN = N*0x10
    for (int n = 1; n < 32; n++) begin
      wr0En = 1'b1; wr0Addr = 5'(n); wr0Data = 32'(n * 16);
      applyStimulus();
    end
    clearInputs();

    // dump with backpressure and capture isolation
    dumpReady = 1'b0; dumpStart = 1'b1;
    applyStimulus();
    dumpStart = 1'b0;
    for (int k = 0; k < 32; k++) begin
      dumpReady = 1'b0;
      if (k == 3) begin wr0En = 1'b1; wr0Addr = 5'd3; wr0Data = 32'hFF; end
      if (k == 5) dumpStart = 1'b1;
      #1;
      checkOutput($sformatf("bp_valid_%0d", k), {31'b0, dumpValid}, 32'd1);
      checkOutput($sformatf("bp_addr_%0d", k), {27'b0, dumpAddr}, 32'(k));
      checkOutput($sformatf("bp_data_%0d", k), dumpData, 32'(k * 16));
      checkOutput($sformatf("bp_last_%0d", k), {31'b0, dumpLast}, (k == 31) ? 32'd1 : 32'd0);
      applyStimulus();
      clearInputs();
      #1;
      checkOutput($sformatf("bp_hold_addr_%0d", k), {27'b0, dumpAddr}, 32'(k));
      checkOutput($sformatf("bp_hold_data_%0d", k), dumpData, 32'(k * 16));
      dumpReady = 1'b1;
      if (k == 3) begin wr0En = 1'b1; wr0Addr = 5'd4; wr0Data = 32'hAB; end
      applyStimulus();
      clearInputs();
    end
    dumpReady = 1'b0;
    #1;
    checkOutput("bp_end_valid", {31'b0, dumpValid}, 32'd0);
    checkOutput("bp_end_last", {31'b0, dumpLast}, 32'd0);

    // full dump with ready held high
    dumpStart = 1'b1;
    applyStimulus();
    dumpStart = 1'b0; dumpReady = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checkOutput($sformatf("full_addr_%0d", i), {27'b0, dumpAddr}, 32'(i));
      checkOutput($sformatf("full_data_%0d", i), dumpData, dumpExpect(i));
      checkOutput($sformatf("full_valid_%0d", i), {31'b0, dumpValid}, 32'd1);
      applyStimulus();
    end
    checkOutput("full_end_valid", {31'b0, dumpValid}, 32'd0);

    // reset in the middle of a dump with busy bits set
    busySetEn = 1'b1; busySetAddr = 5'd9; dumpStart = 1'b1; dumpReady = 1'b0;
    applyStimulus();
    dumpStart = 1'b0; busySetAddr = 5'd12; dumpReady = 1'b1;
    applyStimulus();
    clearInputs();
    for (int i = 0; i < 9; i++) applyStimulus();
    dumpReady = 1'b0; rdAddrA = 5'd9; rdAddrB = 5'd12;
    #1;
    checkOutput("mid_addr", {27'b0, dumpAddr}, 32'd10);
    checkOutput("mid_data", dumpData, 32'hA0);
    checkOutput("mid_busy_a", {31'b0, busyA}, 32'd1);
    checkOutput("mid_busy_b", {31'b0, busyB}, 32'd1);
    checkOutput("mid_rd_a", rdDataA, 32'h90);
    checkOutput("mid_rd_b", rdDataB, 32'hC0);
    rst = 1'b1; wr0En = 1'b1; wr0Addr = 5'd9; wr0Data = 32'h77;
    busySetEn = 1'b1; busySetAddr = 5'd5; dumpStart = 1'b1;
    applyStimulus();
    rst = 1'b0;
    clearInputs();
    #1;
    checkOutput("rst2_valid", {31'b0, dumpValid}, 32'd0);
    checkOutput("rst2_addr", {27'b0, dumpAddr}, 32'd0);
    checkOutput("rst2_data", dumpData, 32'd0);
    checkOutput("rst2_rd_a", rdDataA, 32'd0);
    checkOutput("rst2_rd_b", rdDataB, 32'd0);
    checkOutput("rst2_busy_a", {31'b0, busyA}, 32'd0);
    checkOutput("rst2_busy_b", {31'b0, busyB}, 32'd0);
    rdAddrA = 5'd5;
    #1;
    checkOutput("rst2_busy_r5", {31'b0, busyA}, 32'd0);
    dumpStart = 1'b1;
    applyStimulus();
    dumpStart = 1'b0;
    checkOutput("restart_valid", {31'b0, dumpValid}, 32'd1);
    checkOutput("restart_addr", {27'b0, dumpAddr}, 32'd0);
    checkOutput("restart_data", dumpData, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
